// File: rtl/alu_defs.sv
// Shared definitions for the serial ALU: operation codes, FSM state
// encoding and the default operand width.
package alu_defs;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : alu_defs

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-add / XOR of a single bit pair.
// Ports:
//   a, b   - operand bits (b already conditioned by BInvert)
//   cin    - carry in (only meaningful for OP_ADD)
//   op     - operation select
//   result - logic or sum bit
//   cout   - carry out (0 for logic operations)
module alu_bit_slice
  import alu_defs::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  output logic result,
  output logic cout
);

  always_comb begin
    result = 1'b0;
    cout   = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result = a ^ b ^ cin;
        cout   = (a & b) | (a & cin) | (b & cin);
      end
      OP_XOR: result = a ^ b;
      default: begin
        result = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule : alu_bit_slice

// File: rtl/serial_alu_16bit.sv
// Bit-serial ALU: latches operands on Start, processes one bit per clock
// LSB first through a single alu_bit_slice, then pulses Done for one cycle.
// Ports:
//   Clock, Reset_n     - clock, asynchronous active-low reset
//   Start              - begin an operation (sampled only in IDLE)
//   A, B               - operands
//   BInvert            - invert B and seed carry with 1 (subtract)
//   Operation          - 00 AND, 01 OR, 10 ADD/SUB, 11 XOR
//   Busy               - high while bits are processed
//   Done               - one-cycle pulse, result and flags valid
//   Result             - registered result
//   COUT, Zero, Overflow - flags (COUT/Overflow only for ADD/SUB)
module serial_alu_16bit
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BInvert,
  input  logic [1:0]       Operation,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             COUT,
  output logic             Zero,
  output logic             Overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             binv_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             cout_q;
  logic             zero_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic slice_res;
  logic slice_cout;
  logic is_add;

  alu_bit_slice u_slice (
    .a      (a_q[cnt_q]),
    .b      (b_q[cnt_q] ^ binv_q),
    .cin    (carry_q),
    .op     (op_q),
    .result (slice_res),
    .cout   (slice_cout)
  );

  assign is_add = (op_q == OP_ADD);

  // Result with the current bit merged in, so Zero sees the final MSB.
  always_comb begin
    result_d        = result_q;
    result_d[cnt_q] = slice_res;
  end

  // FSM, bit counter, carry chain and result/flag registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      binv_q   <= 1'b0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            binv_q  <= BInvert;
            op_q    <= op_e'(Operation);
            cnt_q   <= '0;
            carry_q <= BInvert;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          carry_q  <= slice_cout;
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB at this point.
            zero_q  <= (result_d == '0);
            cout_q  <= is_add & slice_cout;
            ovf_q   <= is_add & (carry_q ^ slice_cout);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign COUT     = cout_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule : serial_alu_16bit

// File: tb/tb_serial_alu_16bit.sv
// Scoreboard bench for serial_alu_16bit: the driver pushes expected
// results computed with plain arithmetic; a monitor pops them on Done.
module tb_serial_alu_16bit;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         binv;
  logic [1:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  exp_t last_exp;

  serial_alu_16bit #(.WIDTH(W)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .Start     (start),
    .A         (a),
    .B         (b),
    .BInvert   (binv),
    .Operation (op),
    .Busy      (busy),
    .Done      (done),
    .Result    (result),
    .COUT      (cout),
    .Zero      (zero),
    .Overflow  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ibinv, input logic [1:0] iop);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    bb     = ibinv ? ~ib : ib;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (iop)
      2'b00: e.res = ia & bb;
      2'b01: e.res = ia | bb;
      2'b11: e.res = ia ^ bb;
      default: begin
        sum    = {1'b0, ia} + {1'b0, bb} + (W+1)'(ibinv);
        e.res  = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (ia[W-1] == bb[W-1]) && (e.res[W-1] != ia[W-1]);
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Monitor: compare every Done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("cout", W'(cout), W'(e.cout));
        check("zero", W'(zero), W'(e.zero));
        check("overflow", W'(ovf), W'(e.ovf));
        check("busy_at_done", W'(busy), W'(0));
      end
    end
  end

  // Issue one operation; optionally scramble inputs after Start and
  // pulse Start again while running.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibinv, input logic [1:0] iop,
                        input bit scramble, input bit restart);
    int cyc;
    @(negedge clk);
    a = ia; b = ib; binv = ibinv; op = iop; start = 1'b1;
    last_exp = model(ia, ib, ibinv, iop);
    exp_q.push_back(last_exp);
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); binv = 1'($urandom); op = 2'($urandom);
    end
    check("busy_first", W'(busy), W'(1));
    cyc = 1;
    while (!done && cyc < 100) begin
      start = restart && (cyc == 5 || cyc == 10);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", W'(cyc), W'(W + 1));
    @(negedge clk);
    check("done_pulse_low", W'(done), W'(0));
    check("busy_after", W'(busy), W'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
    check({tag, "_result"}, result, W'(0));
    check({tag, "_cout"}, W'(cout), W'(0));
    check({tag, "_zero"}, W'(zero), W'(1));
    check({tag, "_ovf"}, W'(ovf), W'(0));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    start = 1'b0; a = '0; b = '0; binv = 1'b0; op = 2'b00;
    rst_n = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(16'h7FFF, 16'h0001, 1'b0, 2'b10, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 2'b10, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, 1'b0, 2'b00, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, 1'b0, 2'b01, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, 1'b0, 2'b11, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, 1'b1, 2'b00, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 2'b10, 1'b0, 1'b0);
    // Start pulses while running must be ignored.
    run_op(16'hFFFF, 16'h0001, 1'b0, 2'b10, 1'b0, 1'b1);
    // Operands changed after Start must not matter.
    run_op(16'h1234, 16'h4321, 1'b0, 2'b10, 1'b1, 1'b0);

    // Results hold through idle cycles.
    repeat (3) @(negedge clk);
    check("hold_result", result, last_exp.res);
    check("hold_zero", W'(zero), W'(last_exp.zero));

    // Reset in the middle of RUN aborts with no Done.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; binv = 1'b0; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      check("abort_no_done", W'(done), W'(0));
    end
    run_op(16'h00FF, 16'h0F0F, 1'b0, 2'b10, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_alu_16bit

// File: doc/serial_alu_16bit.md
SERIAL_ALU_16BIT -- requirements
Module: serial_alu_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; must be at least 2.
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1 bit, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits, first operand.
REQ-006 SHALL have port B, input, WIDTH bits, second operand.
REQ-007 SHALL have port BInvert, input, 1 bit, invert B and force initial carry-in to 1 (subtract).
REQ-008 SHALL have port Operation, input, 2 bits: 00 AND, 01 OR, 10 ADD/SUB, 11 XOR.
REQ-009 SHALL have port Busy, output, 1 bit, high while bits are being processed.
REQ-010 SHALL have port Done, output, 1 bit, one-cycle pulse when the result is valid.
REQ-011 SHALL have port Result, output, WIDTH bits, registered result.
REQ-012 SHALL have port COUT, output, 1 bit, carry out of the MSB (ADD/SUB only, else 0).
REQ-013 SHALL have port Zero, output, 1 bit, Result equals 0.
REQ-014 SHALL have port Overflow, output, 1 bit, signed overflow (ADD/SUB only, else 0).

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 In IDLE, Start=1 at edge k SHALL latch A, B, BInvert and Operation, clear the bit counter, load carry with BInvert, and enter RUN.
REQ-017 In RUN, edges k+1..k+WIDTH SHALL each process exactly one bit, LSB first, through one 1-bit slice.
REQ-018 Slice inputs per bit: a[i]; b[i] XOR BInvert; the carry register.
REQ-019 Slice sum/logic bit SHALL be written to Result[i], and the carry register updated with the slice carry-out.
REQ-020 After edge k+WIDTH, state SHALL be DONE, with Done=1, Busy=0, and Result/COUT/Zero/Overflow valid.
REQ-021 Next edge SHALL return to IDLE, with Done=0.
REQ-022 Total latency SHALL be WIDTH+1 cycles from the Start edge to the Done pulse.
REQ-023 Busy SHALL be 1 exactly in RUN.
REQ-024 Start SHALL be ignored in RUN and DONE, with no effect on the in-flight operation.
REQ-025 A/B/Operation/BInvert changes after the Start edge SHALL not affect the result (latched copies are used).
REQ-026 Overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB for Operation=10, and 0 otherwise.
REQ-027 COUT SHALL be 0 for logic operations.
REQ-028 Result and flags SHALL hold their last values in IDLE until the next operation's DONE.
REQ-029 Intermediate Result bits MAY change during RUN and are not valid until Done.
REQ-030 ADD SHALL wrap modulo 2^WIDTH.
REQ-031 BInvert with a logic Operation SHALL apply to B (e.g. AND with ~B).

Reset
REQ-032 Reset_n=0 SHALL asynchronously force IDLE, Busy=0, Done=0, Result=0, COUT=0, Overflow=0, Zero=1, and clear the counter and carry.
REQ-033 Reset during RUN or DONE SHALL abort the operation with no Done pulse.
REQ-034 First Start SHALL be accepted at the first rising edge after Reset_n deasserts.

Structure
REQ-035 Operation codes, FSM state encoding and default WIDTH SHALL live in a shared definitions package, alu_defs.
REQ-036 The one-bit datapath SHALL be a combinational sub-module alu_bit_slice (a, b, cin, op -> result, cout), instantiated once.
REQ-037 FSM, counter, carry and shift/write logic SHALL reside in serial_alu_16bit.

Verification
REQ-038 ADD: A=7FFF, B=0001, BInvert=0, Op=10 -> Done at cycle 17, Result=8000, COUT=0, Overflow=1, Zero=0.
REQ-039 SUB: A=0005, B=0005, BInvert=1, Op=10 -> Result=0000, COUT=1, Zero=1, Overflow=0.
REQ-040 Logic: AND F0F0,0FF0 -> 00F0; OR -> FFF0; XOR -> FF00; COUT=0 and Overflow=0 for each.
REQ-041 Start pulsed at cycles 5 and 10 of a running ADD FFFF+0001 -> single Done pulse, Result=0000, COUT=1, Zero=1.
REQ-042 Reset_n low at cycle 8 of RUN -> Busy=0, Result=0000, no Done; next Start completes normally.
REQ-043 Operands changed on the cycle after Start -> Result reflects the latched operands.
